tone_ref_gen: RTL and testbench
===============================

# tone_ref_gen

Generates the 5-bit duty reference `pwm_ref` that drives the audio PWM comparator. It produces a volume-scaled triangle tone of selectable pitch and fixed duration. The block runs in the divided `clk_out` domain, shared with the PWM period counter. It updates `pwm_ref` only at PWM period boundaries, so every 32-cycle PWM frame uses a single, glitch-free duty value.

## Interface

Parameters:
- `NOTE_PERIODS`, default 2048: note length in PWM frames (1..4095).
- `DUR_W`, default 12: width of the duration counter; must hold `NOTE_PERIODS`.

Ports:
- `clk_out`, in, 1: divided audio clock. Same clock as the PWM counter and comparator.
- `reset`, in, 1: reset, asynchronous, active-high.
- `counter`, in, 5: PWM period counter value (0..31, wraps 31→0).
- `play`, in, 1: request to play a note (level).
- `note_sel`, in, 3: pitch select; hold = `note_sel`+1 frames per triangle step.
- `volume`, in, 2: amplitude select; gain = (`volume`+1)/4.
- `pwm_ref`, out, 5: registered duty reference to the PWM comparator.
- `busy`, out, 1: high while a note is playing.
- `done`, out, 1: one-cycle pulse on natural note completion.

## Operation

- Boundary event: B = (`counter` == 31). All state changes except reset occur only on `clk_out` edges where B is true.
- States: IDLE, PLAY.
- `armed` flag:
  - Set at any B edge where `play` = 0.
  - Cleared on note start.
  - A held-high `play` therefore never retriggers a note.
- IDLE → PLAY at a B edge with `play` = 1 and `armed` = 1. On that edge:
  - Latch `note_sel` and `volume`.
  - Clear `tri` = 0, `dir` = up, `hold_cnt` = 0, `dur_cnt` = 0.
  - Set `busy` = 1.
- In PLAY, at each B edge:
  - `dur_cnt` increments.
  - `hold_cnt` increments. When it reaches the latched `note_sel`, it returns to 0 and `tri` steps.
- Triangle stepping:
  - Going up, `tri` runs 0→31. At 31, `dir` flips to down.
  - Going down, `tri` runs 31→0. At 0, `dir` flips to up.
  - One triangle period = 62 steps = 62·(`note_sel`+1) frames.
- Output: `pwm_ref` = (`tri` · (`vol_latched`+1)) >> 2.
  - 8-bit intermediate product, truncated. Maximum value 31.
  - Registered on the B edge.
- Natural completion, at the B edge where `dur_cnt` reaches `NOTE_PERIODS`−1:
  - Go to IDLE with `pwm_ref` = 0 and `busy` = 0.
  - Pulse `done` = 1 for exactly one `clk_out` cycle.
- Abort: `play` = 0 at any B edge in PLAY.
  - Go to IDLE with `pwm_ref` = 0 and `busy` = 0.
  - No `done` pulse. `armed` is set.
- Abort and completion on the same edge: completion wins, so `done` pulses.
- `note_sel` and `volume` changes during PLAY are ignored until the next note.
- Reset (asynchronous) forces:
  - State IDLE.
  - `pwm_ref` = 0, `busy` = 0, `done` = 0.
  - `armed` = 0, `tri` = 0, all counters 0.
  - Reset mid-note abandons the note with no `done` pulse.
  - After reset, `play` must be seen low at one B edge before the first note can start.

## Timing

- Reset values: `pwm_ref` = 0, `busy` = 0, `done` = 0.
- `pwm_ref`, `busy` and `done` change only on the `clk_out` edge where `counter` goes 31→0.
- The PWM frame starting at `counter` = 0 therefore sees a stable `pwm_ref` for all 32 cycles.
- Start latency: the note begins at the first B edge with `play` = 1 and `armed` = 1.
  - Worst case is 32 `clk_out` cycles after `play` rises.
  - The first frame outputs `pwm_ref` = 0, since `tri` = 0.
- Note length: exactly `NOTE_PERIODS` frames (`NOTE_PERIODS`·32 cycles) from start edge to end edge.
- `done` is high for the single cycle after the final B edge (`counter` = 0). It is low at `counter` = 1.
- Any reset assertion clears the outputs immediately, without waiting for a clock.

## Test plan

- Reset mid-note:
  - Stimulus: assert `reset` during PLAY.
  - Required: `pwm_ref` = 0 and `busy` = 0 immediately; no `done`.
  - Required: with `play` held high after reset release, no note starts until `play` goes low at a B edge and rises again.
- Basic note:
  - Stimulus: `play` pulse, `note_sel` = 0, `volume` = 3, `NOTE_PERIODS` = 100.
  - Required `pwm_ref` frame sequence: 0,1,2,…,31,30,…,0,1,…
  - Required: `busy` high for exactly 100 frames; `done` pulses once, one cycle wide, at `counter` = 0.
- Pitch hold:
  - Stimulus: `note_sel` = 3.
  - Required: each `tri` value held for 4 frames; triangle period = 248 frames.
- Volume scaling:
  - Stimulus: `volume` = 0, 1, 2 at `tri` = 31.
  - Required: `pwm_ref` = 7, 15, 23 respectively; at `tri` = 5 with `volume` = 1, `pwm_ref` = 2.
- Abort:
  - Stimulus: drop `play` mid-note.
  - Required: `pwm_ref` = 0 and `busy` = 0 at the next B edge; `done` stays 0.
  - Stimulus: change `note_sel` and `volume` mid-note.
  - Required: no effect on the current note.
- Held play:
  - Stimulus: keep `play` high through completion.
  - Required: one note only; a second note starts only after `play` is low at a B edge and then high at a later B edge.

Source files
------------

// File: rtl/tone_ref_gen.sv
// Volume-scaled triangle tone reference for the audio PWM comparator.
// All state advances only at PWM frame boundaries (counter == 31).
//
// state | meaning
// IDLE  | no note; pwm_ref held at 0, waiting for an armed play request
// PLAY  | note in progress; triangle steps every sel_lat+1 frames
module tone_ref_gen #(
  parameter int NOTE_PERIODS = 2048,
  parameter int DUR_W        = 12
) (
  input  logic       clk_out,
  input  logic       reset,
  input  logic [4:0] counter,
  input  logic       play,
  input  logic [2:0] note_sel,
  input  logic [1:0] volume,
  output logic [4:0] pwm_ref,
  output logic       busy,
  output logic       done
);

  typedef enum logic {IDLE, PLAY} state_t;

  localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(NOTE_PERIODS - 1);

  state_t           state;
  logic             armed;
  logic [2:0]       sel_lat;
  logic [1:0]       vol_lat;
  logic [4:0]       tri_val;
  logic             dir_up;
  logic [2:0]       hold_cnt;
  logic [DUR_W-1:0] dur_cnt;

  logic             frame_end;
  logic             hold_wrap;
  logic [4:0]       tri_nxt;
  logic             dir_nxt;
  logic [7:0]       prod;
  logic [4:0]       ref_nxt;

  assign frame_end = (counter == 5'd31);
  assign hold_wrap = (hold_cnt == sel_lat);

  always_comb begin
    tri_nxt = tri_val;
    dir_nxt = dir_up;
    if (hold_wrap) begin
      if (dir_up) begin
        if (tri_val == 5'd31) begin
          tri_nxt = 5'd30;
          dir_nxt = 1'b0;
        end else begin
          tri_nxt = tri_val + 5'd1;
        end
      end else begin
        if (tri_val == 5'd0) begin
          tri_nxt = 5'd1;
          dir_nxt = 1'b1;
        end else begin
          tri_nxt = tri_val - 5'd1;
        end
      end
    end
  end

  // Output uses the post-step triangle so the new frame shows the new value.
  assign prod    = 8'(tri_nxt) * (8'(vol_lat) + 8'd1);
  assign ref_nxt = prod[6:2];

  // dur_cnt counts down the frames remaining; zero marks the final frame.
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      armed    <= 1'b0;
      sel_lat  <= 3'd0;
      vol_lat  <= 2'd0;
      tri_val  <= 5'd0;
      dir_up   <= 1'b1;
      hold_cnt <= 3'd0;
      dur_cnt  <= '0;
      pwm_ref  <= 5'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (frame_end) begin
        if (!play) armed <= 1'b1;
        case (state)
          IDLE: begin
            if (play && armed) begin
              state    <= PLAY;
              armed    <= 1'b0;
              sel_lat  <= note_sel;
              vol_lat  <= volume;
              tri_val  <= 5'd0;
              dir_up   <= 1'b1;
              hold_cnt <= 3'd0;
              dur_cnt  <= DUR_LAST;
              pwm_ref  <= 5'd0;
              busy     <= 1'b1;
            end
          end
          PLAY: begin
            if (dur_cnt == '0) begin
              state   <= IDLE;
              pwm_ref <= 5'd0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else if (!play) begin
              state   <= IDLE;
              pwm_ref <= 5'd0;
              busy    <= 1'b0;
            end else begin
              dur_cnt  <= dur_cnt - 1'b1;
              hold_cnt <= hold_wrap ? 3'd0 : hold_cnt + 3'd1;
              tri_val  <= tri_nxt;
              dir_up   <= dir_nxt;
              pwm_ref  <= ref_nxt;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tone_ref_gen.sv
// Directed bench for tone_ref_gen with a 100-frame note length.
module tb_tone_ref_gen;

  logic       clk_out;
  logic       reset;
  logic [4:0] counter;
  logic       play;
  logic [2:0] note_sel;
  logic [1:0] volume;
  logic [4:0] pwm_ref;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  tone_ref_gen #(.NOTE_PERIODS(100), .DUR_W(12)) dut (
    .clk_out  (clk_out),
    .reset    (reset),
    .counter  (counter),
    .play     (play),
    .note_sel (note_sel),
    .volume   (volume),
    .pwm_ref  (pwm_ref),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    clk_out = 1'b0;
    forever #5 clk_out = ~clk_out;
  end

  // PWM period counter, advanced between active edges.
  initial begin
    counter = 5'd0;
    forever begin
      @(negedge clk_out);
      counter = counter + 5'd1;
    end
  end

  always @(negedge clk_out) if (done) done_cnt++;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next frame-boundary edge.
  task automatic next_b();
    @(posedge clk_out);
    while (counter != 5'd31) @(posedge clk_out);
    #1;
  endtask

  function automatic int tri_at(input int steps);
    int p;
    p = steps % 62;
    return (p <= 31) ? p : 62 - p;
  endfunction

  int vol_exp[3] = '{7, 15, 23};

  initial begin
    reset    = 1'b1;
    play     = 1'b0;
    note_sel = 3'd0;
    volume   = 2'd3;
    repeat (3) @(posedge clk_out);
    #1;
    check("rst_pwm", pwm_ref, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    #2 reset = 1'b0;

    // Basic note, play held through completion.
    next_b();
    play = 1'b1;
    next_b();
    check("basic_start_busy", busy, 1);
    check("basic_start_pwm", pwm_ref, 0);
    for (int k = 1; k < 100; k++) begin
      next_b();
      check($sformatf("basic_pwm_f%0d", k), pwm_ref, tri_at(k));
      check($sformatf("basic_busy_f%0d", k), busy, 1);
    end
    next_b();
    check("basic_end_busy", busy, 0);
    check("basic_end_pwm", pwm_ref, 0);
    check("basic_end_done", done, 1);
    #5;
    check("done_at_cnt0", done, 1);
    @(posedge clk_out);
    #1;
    check("done_width", done, 0);
    check("done_count_basic", done_cnt, 1);

    // Held play must not retrigger.
    for (int k = 0; k < 3; k++) begin
      next_b();
      check("held_no_retrig", busy, 0);
    end
    play     = 1'b0;
    note_sel = 3'd3;
    volume   = 2'd3;
    next_b();
    check("rearm_idle", busy, 0);
    play = 1'b1;
    next_b();
    check("pitch_start_busy", busy, 1);
    check("pitch_start_pwm", pwm_ref, 0);

    // Pitch hold with mid-note config change, then abort.
    for (int k = 1; k < 60; k++) begin
      next_b();
      check($sformatf("pitch_pwm_f%0d", k), pwm_ref, k / 4);
      if (k == 50) begin
        note_sel = 3'd0;
        volume   = 2'd0;
      end
    end
    play = 1'b0;
    next_b();
    check("abort_busy", busy, 0);
    check("abort_pwm", pwm_ref, 0);
    @(posedge clk_out);
    #1;
    check("abort_no_done", done_cnt, 1);

    // Volume scaling at tri = 31 and tri = 5.
    for (int v = 0; v < 3; v++) begin
      note_sel = 3'd0;
      volume   = 2'(v);
      play     = 1'b1;
      next_b();
      check($sformatf("vol%0d_start", v), busy, 1);
      for (int k = 1; k <= 31; k++) begin
        next_b();
        if (v == 1 && k == 5) check("vol1_tri5", pwm_ref, 2);
        if (k == 31) check($sformatf("vol%0d_tri31", v), pwm_ref, vol_exp[v]);
      end
      play = 1'b0;
      next_b();
      check($sformatf("vol%0d_abort", v), busy, 0);
    end

    // Reset mid-note.
    note_sel = 3'd0;
    volume   = 2'd3;
    play     = 1'b1;
    next_b();
    for (int k = 1; k <= 10; k++) next_b();
    check("pre_reset_pwm", pwm_ref, 10);
    #7 reset = 1'b1;
    #1;
    check("async_rst_pwm", pwm_ref, 0);
    check("async_rst_busy", busy, 0);
    #20 reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      next_b();
      check("post_rst_held_play", busy, 0);
    end
    play = 1'b0;
    next_b();
    check("post_rst_arm", busy, 0);
    play = 1'b1;
    next_b();
    check("post_rst_start_busy", busy, 1);
    check("post_rst_start_pwm", pwm_ref, 0);
    play = 1'b0;
    next_b();
    check("final_abort", busy, 0);
    check("done_count_total", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
